ahb_sram_slave: RTL
===================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: data/address bus width in bits.
REQ-002 SHALL provide parameter DEPTH, default 1024: memory size in WIDTH-bit words.
REQ-003 SHALL provide parameter WAIT_STATES, default 1, range 0..7: hready_o-low cycles inserted before each read or write completes.
REQ-004 SHALL provide hclk_i  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL provide hresetn_i  input  1: reset, asynchronous, active-low.
REQ-006 SHALL provide hsel_i  input  1: slave select from the address decoder.
REQ-007 SHALL provide htrans_i  input  2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL provide haddr_i  input  WIDTH: byte address.
REQ-009 SHALL provide hwrite_i  input  1: 1=write, 0=read.
REQ-010 SHALL provide hsize_i  input  3: 000 byte, 001 halfword, 010 word.
REQ-011 SHALL provide hburst_i  input  3: burst type; accepted, does not alter timing.
REQ-012 SHALL provide hwdata_i  input  WIDTH: write data, valid in the data phase.
REQ-013 SHALL provide hready_i  input  1: bus HREADY, previous transfer complete.
REQ-014 SHALL provide hready_o  output  1: this slave's data phase complete.
REQ-015 SHALL provide hresp_o  output  2: 00 OKAY, 01 ERROR.
REQ-016 SHALL provide hrdata_o  output  WIDTH: read data, little-endian byte lanes.

Function
REQ-017 SHALL accept an address phase only on an edge where hsel_i=1, hready_i=1 and htrans_i[1]=1; it latches haddr_i, hwrite_i and hsize_i.
REQ-018 SHALL answer IDLE/BUSY transfers and unselected cycles with hready_o=1, hresp_o=OKAY and zero wait states.
REQ-019 SHALL implement these states: IDLE, WAIT (counting wait states), DATA (final data-phase cycle), ERR1, ERR2.
REQ-020 SHALL go from an accepted valid transfer to WAIT when WAIT_STATES>0, otherwise directly to DATA; WAIT SHALL hold hready_o=0 for exactly WAIT_STATES cycles and then go to DATA.
REQ-021 In DATA it SHALL drive hready_o=1 and hresp_o=OKAY; for reads, hrdata_o SHALL present the full addressed word.
REQ-022 For writes, SHALL capture hwdata_i at the DATA-cycle edge and update only the byte lanes selected by the latched haddr[1:0] and hsize.
REQ-023 SHALL treat as an error: word index >= DEPTH, hsize>2, halfword with haddr[0]=1, or word with haddr[1:0]!=0.
REQ-024 On an error it SHALL give a two-cycle response: ERR1 (hready_o=0, hresp_o=ERROR), then ERR2 (hready_o=1, hresp_o=ERROR), with no memory update.
REQ-025 SHALL be able to accept a new address phase in the DATA or ERR2 cycle (pipelined back-to-back transfers) without an idle cycle; with no new transfer it SHALL return to IDLE.
REQ-026 A read whose data phase follows a write to the same word SHALL return the newly written bytes.
REQ-027 A transfer accepted while the slave is in WAIT/ERR1 is impossible by protocol, because hready_i=0 then; the slave SHALL ignore address-phase inputs in those states.
REQ-028 hrdata_o SHALL be 0 in every cycle other than a read DATA cycle.

Reset
REQ-029 While hresetn_i=0, SHALL force state=IDLE, hready_o=1, hresp_o=OKAY, hrdata_o=0 and clear the wait counter.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted during WAIT or DATA of a write SHALL abort it with no memory update.

Verification
REQ-032 Word write 0xDEADBEEF to 0x10, then read 0x10 with WAIT_STATES=1 -> each data phase shows 1 cycle hready_o=0 then hready_o=1/OKAY; read returns 0xDEADBEEF.
REQ-033 After writing 0x00000000 to 0x20, byte write 0xAB at 0x22 (hwdata 0x00AB0000), then word read of 0x20 -> 0x00AB0000.
REQ-034 Word read at 0x02 (misaligned) and at byte address DEPTH*4 -> each gives ERR1 (hready_o=0, ERROR) then ERR2 (hready_o=1, ERROR); memory unchanged.
REQ-035 WAIT_STATES=0: back-to-back NONSEQ write 0x12345678 @0x0 then read @0x0 -> no hready_o low; read data 0x12345678 one cycle after the write data phase.
REQ-036 hresetn_i pulsed low during the wait cycle of a write of 0x55 to 0x40 -> outputs go immediately to hready_o=1, OKAY, hrdata_o=0; a later read of 0x40 returns the pre-write value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave with programmable wait states, byte-lane writes
// and a two-cycle ERROR response for out-of-range or misaligned transfers.
module ahb_sram_slave #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic             hclk_i,
    input  logic             hresetn_i,
    input  logic             hsel_i,
    input  logic [1:0]       htrans_i,
    input  logic [WIDTH-1:0] haddr_i,
    input  logic             hwrite_i,
    input  logic [2:0]       hsize_i,
    input  logic [2:0]       hburst_i,
    input  logic [WIDTH-1:0] hwdata_i,
    input  logic             hready_i,
    output logic             hready_o,
    output logic [1:0]       hresp_o,
    output logic [WIDTH-1:0] hrdata_o
);

    localparam int NB   = WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
    localparam logic [2:0] WS_M1 = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              hready_q, hready_d;
    logic [1:0]        hresp_q, hresp_d;
    logic              rd_q, rd_d;

    logic              accept;
    logic              req_err;
    logic [NB-1:0]     strb;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Burst type and the SEQ/NONSEQ distinction do not affect this slave.
    logic unused_inputs;
    assign unused_inputs = ^{hburst_i, htrans_i[0]};

    // WAIT and ERR1 are never exited with hready_i high, so only the
    // remaining states may take a new address phase.
    assign accept = (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2)
                    && hsel_i && hready_i && htrans_i[1];

    assign req_err = ({{OFFW{1'b0}}, haddr_i[WIDTH-1:OFFW]} >= DEPTH_W)
                     || (hsize_i > 3'd2)
                     || (hsize_i == 3'd1 && haddr_i[0])
                     || (hsize_i == 3'd2 && haddr_i[OFFW-1:0] != '0);

    // NOTE: every signal gets a default at the top of always_comb so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = haddr_i[OFFW +: AW];
                    off_d   = haddr_i[OFFW-1:0];
                    size_d  = hsize_i;
                    write_d = hwrite_i;
                    if (req_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_M1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
        hready_d = !(state_d == S_WAIT || state_d == S_ERR1);
        hresp_d  = (state_d == S_ERR1 || state_d == S_ERR2) ? RESP_ERROR : RESP_OKAY;
        rd_d     = (state_d == S_DATA) && !write_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            off_q    <= '0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        case (size_q)
            3'd0:    strb = NB'(1) << off_q;
            3'd1:    strb = NB'(3) << off_q;
            default: strb = '1;
        endcase
    end

    // NOTE: the array has no reset; contents survive hresetn_i. A reset
    // forces state_q to IDLE, which alone blocks an in-flight write.
    always_ff @(posedge hclk_i) begin
        if (state_q == S_DATA && write_q) begin
            for (int b = 0; b < NB; b++) begin
                if (strb[b]) mem[idx_q][b*8 +: 8] <= hwdata_i[b*8 +: 8];
            end
        end
    end

    // Array read is combinational so a read right after a write sees the new bytes.
    assign hrdata_o = rd_q ? mem[idx_q] : '0;
    assign hready_o = hready_q;
    assign hresp_o  = hresp_q;

endmodule
